// File: rtl/decoder_pkg.sv
// Shared types, sizes and the round-robin pick helper for the select-decode arbiter.
package decoder_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    // Walk downward so the lowest offset from ptr (first ascending hit) is written last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] win;
        logic [SEL_W-1:0] idx;
        win = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/decoder_4to16.sv
// Active-low 4-to-16 decoder: one output pulled low when the active-low enable is asserted.
module decoder_4to16
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               en_in,
    output logic [NUM_REQ-1:0] y_n_out
);

    always_comb begin
        y_n_out = '1;
        if (!en_in) begin
            y_n_out[sel_in] = 1'b0;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin sequencer driving the shared active-low select decode, with hold limit
// and a break-before-make gap between grants.
module decoder_rr_arbiter
    import decoder_pkg::*;
#(
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [SEL_W-1:0]   sel_out,
    output logic               en_n_out,
    output logic [NUM_REQ-1:0] gnt_n_out,
    output logic               busy_out,
    output logic               timeout_out
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [7:0]       hold;
    logic [7:0]       hold_next;
    logic [3:0]       gap;
    logic [3:0]       gap_next;
    logic [SEL_W-1:0] sel_next;
    logic             en_n_next;
    logic             timeout_next;
    logic [SEL_W-1:0] winner;

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        hold_next    = hold;
        gap_next     = gap;
        sel_next     = sel_out;
        en_n_next    = en_n_out;
        timeout_next = 1'b0;
        winner       = rr_pick(req_in, ptr);

        case (state)
            IDLE: begin
                if (|req_in) begin
                    sel_next   = winner;
                    en_n_next  = 1'b0;
                    hold_next  = 8'd0;
                    ptr_next   = winner + SEL_W'(1);
                    state_next = GRANT;
                end
            end
            GRANT: begin
                hold_next = hold + 8'd1;
                // A release in the final hold cycle is a normal release, not a timeout.
                if (!req_in[sel_out]) begin
                    en_n_next  = 1'b1;
                    gap_next   = 4'd0;
                    state_next = GAP;
                end else if (hold == 8'(MAX_HOLD - 1)) begin
                    en_n_next    = 1'b1;
                    gap_next     = 4'd0;
                    timeout_next = 1'b1;
                    state_next   = GAP;
                end
            end
            GAP: begin
                gap_next = gap + 4'd1;
                if (gap == 4'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            ptr         <= '0;
            hold        <= 8'd0;
            gap         <= 4'd0;
            sel_out     <= '0;
            en_n_out    <= 1'b1;
            busy_out    <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            hold        <= hold_next;
            gap         <= gap_next;
            sel_out     <= sel_next;
            en_n_out    <= en_n_next;
            busy_out    <= (state_next != IDLE);
            timeout_out <= timeout_next;
        end
    end

    decoder_4to16 u_decode (
        .sel_in  (sel_out),
        .en_in   (en_n_out),
        .y_n_out (gnt_n_out)
    );

endmodule
